vga_timing_gen: RTL and testbench

//   Generates VGA 640x480@60 raster timing from the 100 MHz board clock: pixel-rate enable,

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel colour stage and connector.
// Optional frame outputs are present only when VGA_FRAME_TICK_EN is defined.
interface vga_timing_gen_if;
    logic       pixTick;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
`ifdef VGA_FRAME_TICK_EN
    logic       frameTick;
    logic [7:0] frameCount;
`endif

    modport master (
        output pixTick, hCount, vCount, hSync, vSync, bright
`ifdef VGA_FRAME_TICK_EN
        , output frameTick, frameCount
`endif
    );

    modport slave (
        input pixTick, hCount, vCount, hSync, vSync, bright
`ifdef VGA_FRAME_TICK_EN
        , input frameTick, frameCount
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v counters, active-low syncs and
// the active-video flag. Syncs and bright are registered from the next-state counters
// so they line up with the counters presented in the same cycle.
// Optional feature macro: VGA_FRAME_TICK_EN adds frameTick/frameCount.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 783,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 514
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S_C = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_ACT_E_C = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_ACT_S_C = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_ACT_E_C = CNT_W'(V_ACT_END);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_sync;
    logic             v_sync;
    logic             bright;
    logic             pix_tick_c;

    assign pix_tick_c = (div_cnt == DIV_LAST);

    // Next raster position; counters move only on pixel ticks.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (pix_tick_c) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                if (v_count == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = v_count + CNT_W'(1);
                end
            end else begin
                h_next = h_count + CNT_W'(1);
            end
        end
    end

    // Divider, counters and sync/bright registers decoded from the next position.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_count <= '0;
            v_count <= '0;
            h_sync  <= 1'b0;
            v_sync  <= 1'b0;
            bright  <= 1'b0;
        end else begin
            div_cnt <= pix_tick_c ? '0 : div_cnt + DIV_W'(1);
            h_count <= h_next;
            v_count <= v_next;
            h_sync  <= (h_next >= H_SYNC_C);
            v_sync  <= (v_next >= V_SYNC_C);
            bright  <= (h_next >= H_ACT_S_C) && (h_next <= H_ACT_E_C) &&
                       (v_next >= V_ACT_S_C) && (v_next <= V_ACT_E_C);
        end
    end

    assign vga.pixTick = pix_tick_c;
    assign vga.hCount  = h_count;
    assign vga.vCount  = v_count;
    assign vga.hSync   = h_sync;
    assign vga.vSync   = v_sync;
    assign vga.bright  = bright;

`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick;
    logic [7:0] frame_count;
    logic       frame_wrap_c;

    assign frame_wrap_c = pix_tick_c && (h_count == H_LAST) && (v_count == V_LAST);

    // One-clk pulse after the (last, last) -> (0, 0) edge, plus a free-running frame count.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_tick <= frame_wrap_c;
            if (frame_wrap_c) begin
                frame_count <= frame_count + 8'(1);
            end
        end
    end

    assign vga.frameTick  = frame_tick;
    assign vga.frameCount = frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Horizontal timing uses the 640x480 values;
// the frame is shortened vertically so a full frame wrap fits in a short run.
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_TOTAL     = 12;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT_END   = 783;
    localparam int unsigned V_ACT_START = 3;
    localparam int unsigned V_ACT_END   = 9;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   t_cyc;
    logic [32:0] sb[$];

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
        .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
        .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs in cycle t after the last reset edge (t=1 is the first such cycle).
    function automatic logic [32:0] model_at(input int t);
        int n, h, lines, v, frames;
        logic pix, hs, vs, br, ft;
        logic [7:0] fc;
        n      = (t - 1) / int'(CLK_DIV);
        h      = n % int'(H_TOTAL);
        lines  = n / int'(H_TOTAL);
        v      = lines % int'(V_TOTAL);
        frames = lines / int'(V_TOTAL);
        pix    = ((t % int'(CLK_DIV)) == 0);
        hs     = (h >= int'(H_SYNC));
        vs     = (v >= int'(V_SYNC));
        br     = (h >= int'(H_ACT_START)) && (h <= int'(H_ACT_END)) &&
                 (v >= int'(V_ACT_START)) && (v <= int'(V_ACT_END));
`ifdef VGA_FRAME_TICK_EN
        ft = ((t - 1) % int'(CLK_DIV) == 0) && (n > 0) &&
             (n % int'(H_TOTAL * V_TOTAL) == 0);
        fc = 8'(frames % 256);
`else
        ft = 1'b0;
        fc = 8'h0;
`endif
        return {pix, 10'(h), 10'(v), hs, vs, br, ft, fc};
    endfunction

    function automatic logic [32:0] dut_vec();
`ifdef VGA_FRAME_TICK_EN
        return {vga.pixTick, vga.hCount, vga.vCount, vga.hSync, vga.vSync, vga.bright,
                vga.frameTick, vga.frameCount};
`else
        return {vga.pixTick, vga.hCount, vga.vCount, vga.hSync, vga.vSync, vga.bright,
                1'b0, 8'h0};
`endif
    endfunction

    // Scoreboard producer: expected state for the cycle that each edge starts.
    initial begin
        t_cyc = 0;
        forever begin
            @(posedge clk);
            if (reset) t_cyc = 1;
            else       t_cyc = t_cyc + 1;
            sb.push_back(model_at(t_cyc));
        end
    end

    // Scoreboard consumer: compare every cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                check_eq("raster", longint'(dut_vec()), longint'(e));
            end
        end
    end

    // Wait (at negedges) for the first cycle showing raster position (h, v).
    task automatic wait_pos(input int h, input int v, input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(vga.hCount) == h && int'(vga.vCount) == v) break;
        end
        if (i >= budget) check_eq({"timeout_", tag}, 0, 1);
    endtask

    // Count negedges until pixTick is seen, bounded.
    task automatic cycles_to_tick(output int n);
        n = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (vga.pixTick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests  = 0;
        failed = 0;
        reset  = 1'b1;

        // Reset held 3 clks
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hcount", longint'(vga.hCount), 0);
        check_eq("rst_vcount", longint'(vga.vCount), 0);
        check_eq("rst_hsync", longint'(vga.hSync), 0);
        check_eq("rst_vsync", longint'(vga.vSync), 0);
        check_eq("rst_bright", longint'(vga.bright), 0);
        check_eq("rst_pixtick", longint'(vga.pixTick), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // First tick and tick period
        cycles_to_tick(n);
        check_eq("first_tick", longint'(n), 4);
        for (int k = 0; k < 3; k++) begin
            cycles_to_tick(n);
            check_eq("tick_period", longint'(n), 4);
        end
        repeat (24) @(negedge clk);
        check_eq("hcount_40clk", longint'(vga.hCount), 9);

        // hSync low width on line 1 and the line wrap
        wait_pos(0, 1, 5000, "line1");
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (vga.hSync) break;
            n++;
            @(negedge clk);
        end
        check_eq("hsync_low_clks", longint'(n), 384);
        wait_pos(H_TOTAL - 1, 1, 5000, "h799");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vga.hCount != 10'(H_TOTAL - 1)) break;
        end
        check_eq("wrap_hcount", longint'(vga.hCount), 0);
        check_eq("wrap_vcount", longint'(vga.vCount), 2);
        check_eq("vsync_line2", longint'(vga.vSync), 1);

        // Active-window edges
        wait_pos(200, 2, 5000, "b200_2");
        check_eq("bright_v_before", longint'(vga.bright), 0);
        wait_pos(143, 3, 5000, "b143");
        check_eq("bright_h143", longint'(vga.bright), 0);
        wait_pos(144, 3, 5000, "b144");
        check_eq("bright_h144", longint'(vga.bright), 1);
        wait_pos(200, 3, 5000, "b200_3");
        check_eq("bright_v_first", longint'(vga.bright), 1);
        wait_pos(783, 3, 5000, "b783");
        check_eq("bright_h783", longint'(vga.bright), 1);
        wait_pos(784, 3, 5000, "b784");
        check_eq("bright_h784", longint'(vga.bright), 0);
        wait_pos(200, V_ACT_END, 30000, "b200_last");
        check_eq("bright_v_last", longint'(vga.bright), 1);
        wait_pos(200, V_ACT_END + 1, 5000, "b200_after");
        check_eq("bright_v_after", longint'(vga.bright), 0);

        // Frame wrap
        wait_pos(H_TOTAL - 1, V_TOTAL - 1, 20000, "last_px");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vga.hCount == 10'd0) break;
        end
        check_eq("fwrap_vcount", longint'(vga.vCount), 0);
        check_eq("fwrap_vsync", longint'(vga.vSync), 0);
`ifdef VGA_FRAME_TICK_EN
        check_eq("frame_tick_hi", longint'(vga.frameTick), 1);
        check_eq("frame_count", longint'(vga.frameCount), 1);
        @(negedge clk);
        check_eq("frame_tick_lo", longint'(vga.frameTick), 0);
`endif
        wait_pos(H_TOTAL - 1, 1, 10000, "f_line1");
        check_eq("vsync_line1", longint'(vga.vSync), 0);
        wait_pos(0, 2, 100, "f_line2");
        check_eq("vsync_line2b", longint'(vga.vSync), 1);

        // Mid-frame reset for one clk
        wait_pos(400, 5, 20000, "mid");
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_hcount", longint'(vga.hCount), 0);
        check_eq("mrst_vcount", longint'(vga.vCount), 0);
        check_eq("mrst_hsync", longint'(vga.hSync), 0);
        check_eq("mrst_bright", longint'(vga.bright), 0);
        check_eq("mrst_pixtick", longint'(vga.pixTick), 0);
`ifdef VGA_FRAME_TICK_EN
        check_eq("mrst_fcount", longint'(vga.frameCount), 0);
`endif
        cycles_to_tick(n);
        check_eq("mrst_first_tick", longint'(n), 3);
        @(negedge clk);
        check_eq("mrst_restart_h", longint'(vga.hCount), 1);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
